// File: rtl/frame_mem_arbiter_if.sv
// Frame memory arbiter bus: VGA read stream, single writer port and the
// single-port RAM side, bundled so the arbiter and its environment share one
// definition.
interface frame_mem_arbiter_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 19
);
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              frame_sync;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;
  logic              underrun;
  logic              underrun_clr;

  // Arbiter side
  modport slave (
    input  rd_en, frame_sync, wr_req, wr_addr, wr_data, mem_rdata, underrun_clr,
    output rd_data, rd_valid, wr_ack, mem_addr, mem_wdata, mem_we, mem_re, underrun
  );

  // Environment side: VGA data path, writer and RAM
  modport master (
    output rd_en, frame_sync, wr_req, wr_addr, wr_data, mem_rdata, underrun_clr,
    input  rd_data, rd_valid, wr_ack, mem_addr, mem_wdata, mem_we, mem_re, underrun
  );
endinterface

// File: rtl/frame_mem_arbiter.sv
// Shares one single-port synchronous frame RAM between the VGA read stream
// (4-entry show-ahead prefetch FIFO) and a single pixel writer.
module frame_mem_arbiter #(
  parameter int DATA_W       = 24,
  parameter int ADDR_W       = 19,
  parameter int FRAME_PIXELS = 307200,
  parameter int STARVE_MAX   = 8
) (
  input logic               clock,
  input logic               reset,
  frame_mem_arbiter_if.slave bus
);

  localparam int                STARVE_W  = $clog2(STARVE_MAX + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   fifo_mem [4];
  logic [1:0]          head_q, tail_q;
  logic [2:0]          count_q;
  logic [ADDR_W-1:0]   rd_addr_q, mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                underrun_q;
  logic [STARVE_W-1:0] starve_q;
  logic [3:0]          credit;
  logic                rd_valid, mem_re, mem_we;
  logic                wr_pend, force_wr, push, pop;

  // The state register doubles as the registered memory command: READ drives
  // mem_re, WRITE drives mem_we/wr_ack, so a read is in flight exactly while
  // state_q == READ and its data is captured at the following edge.
  assign mem_re   = (state_q == READ);
  assign mem_we   = (state_q == WRITE);
  assign rd_valid = (count_q != 3'd0);
  assign credit   = {1'b0, count_q} + {3'b000, mem_re};
  // A request already being acknowledged this cycle must not win a second write.
  assign wr_pend  = bus.wr_req & ~mem_we;
  assign force_wr = wr_pend && (starve_q >= STARVE_W'(STARVE_MAX)) && (count_q >= 3'd2);
  assign push     = mem_re & ~bus.frame_sync;
  assign pop      = bus.rd_en & rd_valid & ~bus.frame_sync;

  assign bus.rd_data   = fifo_mem[head_q];
  assign bus.rd_valid  = rd_valid;
  assign bus.wr_ack    = mem_we;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we;
  assign bus.mem_re    = mem_re;
  assign bus.underrun  = underrun_q;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Arbitration: flush, forced write, prefetch read, opportunistic write, idle
  always_comb begin
    state_d = IDLE;
    if (bus.frame_sync)          state_d = FLUSH;
    else if (force_wr)           state_d = WRITE;
    else if (credit < 4'd4)      state_d = READ;
    else if (wr_pend)            state_d = WRITE;
  end

  // Prefetch FIFO; a flush empties it and drops the read currently returning
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < 4; i++) fifo_mem[i] <= '0;
    end else if (bus.frame_sync) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        fifo_mem[tail_q] <= bus.mem_rdata;
        tail_q           <= tail_q + 2'd1;
      end
      if (pop) head_q <= head_q + 2'd1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Registered memory address/data and the frame read pointer
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_addr_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_d)
        READ: begin
          mem_addr_q <= rd_addr_q;
          rd_addr_q  <= (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + ADDR_W'(1);
        end
        WRITE: begin
          mem_addr_q  <= bus.wr_addr;
          mem_wdata_q <= bus.wr_data;
        end
        FLUSH:   rd_addr_q <= '0;
        default: ;
      endcase
    end
  end

  // Writer starvation counter: consecutive pending cycles without a grant
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                           starve_q <= '0;
    else if (state_d == WRITE || !wr_pend) starve_q <= '0;
    else if (starve_q < STARVE_W'(STARVE_MAX)) starve_q <= starve_q + STARVE_W'(1);
  end

  // Sticky underrun flag; a new event outranks a coincident clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) underrun_q <= 1'b0;
    else        underrun_q <= (underrun_q & ~bus.underrun_clr) | (bus.rd_en & ~rd_valid);
  end

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Self-checking bench for frame_mem_arbiter: read-stream and write
// scoreboards, arbitration, flush, underrun and reset behaviour.
module tb_frame_mem_arbiter;

  localparam int DW = 24;
  localparam int AW = 19;
  localparam int FP = 40;
  localparam int SM = 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  frame_mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  frame_mem_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .FRAME_PIXELS(FP), .STARVE_MAX(SM)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int ack_cnt = 0;
  int writes_issued = 0;
  int excl_err = 0;
  int exp_addr = 0;
  logic [DW-1:0] exp_q[$];
  wr_t           wr_q[$];

  // Frame memory contents, a fixed function of address
  function automatic logic [DW-1:0] pixel(input int a);
    logic [31:0] p;
    p = a * 32'h713;
    return p[DW-1:0] ^ 24'h5A3C00;
  endfunction

  // Read-only RAM model: data valid in the cycle mem_re is high
  always_comb begin
    bus.mem_rdata = '0;
    if (bus.mem_re) bus.mem_rdata = pixel(int'(bus.mem_addr));
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic exp_fill(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(pixel(exp_addr));
      exp_addr = (exp_addr + 1) % FP;
    end
  endtask

  task automatic exp_rewind();
    exp_q.delete();
    exp_addr = 0;
  endtask

  task automatic issue_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    wr_q.push_back(w);
    writes_issued++;
    bus.wr_req  = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
  endtask

  // One clock: check the pop about to happen, step, then monitor the write side
  task automatic tick();
    wr_t w;
    if (bus.rd_en && !bus.frame_sync && bus.rd_valid) begin
      pops++;
      if (exp_q.size() == 0) chk("pop_unexp", bus.rd_valid, 0);
      else                   chk("rd_data", bus.rd_data, exp_q.pop_front());
    end
    @(posedge clock);
    #1;
    if (bus.mem_we && bus.mem_re) excl_err++;
    if (bus.wr_ack) ack_cnt++;
    if (bus.mem_we || bus.wr_ack) chk("wr_ack_eq_we", bus.wr_ack, bus.mem_we);
    if (bus.mem_we) begin
      if (wr_q.size() == 0) chk("wr_unexp", bus.mem_we, 0);
      else begin
        w = wr_q.pop_front();
        chk("wr_addr", bus.mem_addr, w.addr);
        chk("wr_data", bus.mem_wdata, w.data);
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen;
    bus.rd_en = 0; bus.frame_sync = 0; bus.wr_req = 0;
    bus.wr_addr = '0; bus.wr_data = '0; bus.underrun_clr = 0;

    // Reset values
    #12;
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_wr_ack", bus.wr_ack, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_re", bus.mem_re, 0);
    chk("rst_underrun", bus.underrun, 0);
    @(negedge clock);
    reset = 1'b1;

    // Prefetch fill: reads 0..3 then stop
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("fill_re", bus.mem_re, (i < 4) ? 1 : 0);
      if (i < 4) chk("fill_addr", bus.mem_addr, i);
      if (i == 0) chk("fill_valid_k", bus.rd_valid, 0);
      if (i == 1) chk("fill_valid_k1", bus.rd_valid, 1);
    end
    tick();
    chk("full_re_idle", bus.mem_re, 0);
    chk("full_valid", bus.rd_valid, 1);
    chk("full_head", bus.rd_data, pixel(0));

    // Write with FIFO full
    issue_write(19'h100, 24'hABCDEF);
    tick();
    chk("wfull_we", bus.mem_we, 1);
    chk("wfull_ack", bus.wr_ack, 1);
    bus.wr_req = 0;
    tick();
    chk("wfull_we_drop", bus.mem_we, 0);
    chk("wfull_ack_pulse", bus.wr_ack, 0);

    // Full-frame stream plus one wrap
    exp_fill(FP + 1);
    pops = 0;
    bus.rd_en = 1;
    n = 0;
    while (pops < FP + 1 && n < 4 * FP) begin
      tick();
      n++;
    end
    bus.rd_en = 0;
    chk("stream_pops", pops, FP + 1);
    chk("stream_underrun", bus.underrun, 0);
    chk("stream_q_left", exp_q.size(), 0);

    // Forced write under continuous reading
    ticks(4);
    exp_fill(64);
    bus.rd_en = 1;
    ticks(6);
    issue_write(19'h1F0, 24'h123456);
    n = 0;
    seen = 0;
    while (!seen && n < 30) begin
      tick();
      n++;
      if (bus.wr_ack) begin
        seen = 1;
        bus.wr_req = 0;
      end
    end
    chk("force_seen", seen, 1);
    chk("force_lat_ok", (n <= SM + 1) ? 1 : 0, 1);
    ticks(4);
    bus.rd_en = 0;
    chk("force_underrun", bus.underrun, 0);

    // Flush with a read in flight, coincident pop and write request
    ticks(4);
    bus.rd_en = 1;
    tick();
    bus.rd_en = 0;
    tick();
    chk("pre_flush_re", bus.mem_re, 1);
    bus.frame_sync = 1;
    bus.rd_en = 1;
    issue_write(19'h1AA, 24'h00FF00);
    tick();
    chk("flush_valid", bus.rd_valid, 0);
    chk("flush_re", bus.mem_re, 0);
    chk("flush_we", bus.mem_we, 0);
    chk("flush_ack", bus.wr_ack, 0);
    chk("flush_underrun", bus.underrun, 0);
    bus.frame_sync = 0;
    bus.rd_en = 0;
    exp_rewind();
    tick();
    chk("post_flush_re", bus.mem_re, 1);
    chk("post_flush_addr", bus.mem_addr, 0);
    n = 0;
    seen = 0;
    while (!seen && n < 10) begin
      tick();
      n++;
      if (bus.wr_ack) begin
        seen = 1;
        bus.wr_req = 0;
      end
    end
    chk("deferred_wr_seen", seen, 1);
    exp_fill(3);
    pops = 0;
    bus.rd_en = 1;
    ticks(3);
    bus.rd_en = 0;
    chk("post_flush_pops", pops, 3);

    // Underrun: set, sticky, clear vs new event, clear
    bus.frame_sync = 1;
    tick();
    bus.frame_sync = 0;
    exp_rewind();
    bus.rd_en = 1;
    tick();
    bus.rd_en = 0;
    chk("underrun_set", bus.underrun, 1);
    ticks(2);
    chk("underrun_sticky", bus.underrun, 1);
    bus.frame_sync = 1;
    tick();
    bus.frame_sync = 0;
    exp_rewind();
    bus.rd_en = 1;
    bus.underrun_clr = 1;
    tick();
    bus.rd_en = 0;
    chk("underrun_clr_vs_event", bus.underrun, 1);
    tick();
    bus.underrun_clr = 0;
    chk("underrun_cleared", bus.underrun, 0);
    tick();
    chk("underrun_stays_clr", bus.underrun, 0);

    // Reset in the middle of a write
    ticks(6);
    issue_write(19'h101, 24'h777777);
    tick();
    chk("midw_we", bus.mem_we, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("midw_rst_we", bus.mem_we, 0);
    chk("midw_rst_ack", bus.wr_ack, 0);
    chk("midw_rst_re", bus.mem_re, 0);
    chk("midw_rst_valid", bus.rd_valid, 0);
    chk("midw_rst_addr", bus.mem_addr, 0);
    bus.wr_req = 0;
    exp_rewind();
    @(negedge clock);
    reset = 1'b1;
    tick();
    chk("rerun_re", bus.mem_re, 1);
    chk("rerun_addr", bus.mem_addr, 0);

    chk("exclusive_ops", excl_err, 0);
    chk("wr_q_drained", wr_q.size(), 0);
    chk("ack_count", ack_cnt, writes_issued);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
